decode_stage: RTL
=================

# decode_stage

Decode stage of the RV64I+Zba five-stage pipeline, sitting between the fetch/decode pipeline register and the decode/execute pipeline register. It holds the 32×64 architectural register file, decodes the 32-bit instruction into control signals, and generates the sign-extended immediate. It produces every decode-side signal the decode/execute register latches, plus source indices and funct3 for the hazard and execute logic. The register file is written from the writeback stage, with same-cycle write-to-read bypass.

## Interface
- Parameters: none.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- Instr_D  in  32  instruction from the fetch/decode register
- PC_D_in  in  64  PC of Instr_D
- RegWrite_W  in  1  writeback write enable
- Rd_W  in  5  writeback destination
- Result_W  in  64  writeback data
- RD1_D, RD2_D  out  64  rs1/rs2 read data (bypassed)
- PC_D  out  64  PC_D_in passed through
- ImmExt_D  out  64  sign-extended immediate
- Rd_D, Rs1_D, Rs2_D  out  5  instruction register fields (Rs1_D forced 0 for LUI)
- Funct3_D  out  3  Instr_D[14:12], for the branch and memory-width logic
- RegWrite_D, MemWrite_D, ALUSrc_D, Branch_D, Jump_D  out  1 each  control
- ResultSrc_D  out  2  00 ALU, 01 memory, 10 PC+4, 11 PC+Imm
- ALUControl_D  out  4  ALU operation
- Illegal_D  out  1  unsupported or unknown opcode/funct

## Operation
- Register file: 32×64 flops; x0 reads 0 and is never written.
- Write: at posedge clk when RegWrite_W=1 and Rd_W≠0, regs[Rd_W] ← Result_W.
- Read bypass: if RegWrite_W=1, Rd_W≠0, and Rd_W equals a source index, that port returns Result_W, not the stored value.
- ALUControl encoding: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU, 1010 SH1ADD, 1011 SH2ADD, 1100 SH3ADD, 1101 ADD.UW; 1110 and 1111 are reserved.
- Decode by opcode:
  - OP: RegWrite=1, ALUSrc=0, ResultSrc=00.
  - OP-IMM: as OP but ALUSrc=1; shamt is 6 bits; funct6 selects SRL/SRA.
  - LOAD: RegWrite=1, ALUSrc=1, ADD, ResultSrc=01.
  - STORE: MemWrite=1, ALUSrc=1, ADD.
  - BRANCH: Branch=1, ALUSrc=0. ALUControl is SUB for BEQ/BNE, SLT for BLT/BGE, SLTU for BLTU/BGEU; polarity comes from Funct3_D.
  - JAL: Jump=1, RegWrite=1, ResultSrc=10, ALUSrc=0 (target PC+Imm).
  - JALR: Jump=1, RegWrite=1, ResultSrc=10, ALUSrc=1, ADD (target rs1+Imm).
  - LUI: RegWrite=1, ALUSrc=1, ADD, Rs1_D=0.
  - AUIPC: RegWrite=1, ResultSrc=11.
- Immediate formats: I, S, B, U, J per the ISA, sign-extended from the instruction MSB to 64 bits. For R-type, ImmExt_D=0.
- OP-32, OP-IMM-32, FENCE, SYSTEM and unknown opcodes set Illegal_D=1. For these, all write/branch/jump/memory enables are 0 (bubble-equivalent).

## Timing
- Decode, immediate, and read paths are combinational from Instr_D and the W inputs, with zero-cycle latency.
- Register file update is visible to stored reads one cycle after the write edge. Same-cycle reads see it via the bypass.
- Reset:
  - While rst=1, all 32 registers clear asynchronously, writes are blocked, and the bypass is suppressed, so RD1_D=RD2_D=0.
  - Control outputs remain a pure function of Instr_D.
  - Reset asserted mid-write: the write is discarded.
- Writes to x0 are ignored. A bypass match on x0 never fires.

## Configuration
- Macro ZBA_EN.
- Defined: OP with funct7=0010000 and funct3 010/100/110 decodes as SH1ADD/SH2ADD/SH3ADD. OP-32 with funct7=0000100 and funct3 000 (ADD.UW) decodes as 1101 and clears Illegal_D.
- Undefined: those encodings set Illegal_D=1 with all enables 0, and ALUControl codes 1010–1101 are never produced.

## Test plan
- Reset, then write x5←0x1234 via W and read rs1=5 → RD1_D=0x1234 in the same cycle (bypass) and after the edge (stored).
- RegWrite_W=1, Rd_W=0, Result_W=0xFF; then read x0 → RD1_D=0.
- Instr_D=0xFFF00093 (addi x1,x0,-1) → ImmExt_D=0xFFFF_FFFF_FFFF_FFFF, ALUSrc_D=1, ALUControl_D=0000, RegWrite_D=1.
- BNE x1,x2,-4 → Branch_D=1, ALUControl_D=0001, Funct3_D=001, ImmExt_D=−4. JALR x1,0(x2) → Jump_D=1, ALUSrc_D=1, ResultSrc_D=10.
- sh2add x3,x1,x2: with ZBA_EN → ALUControl_D=1011, Illegal_D=0. Without ZBA_EN → Illegal_D=1, RegWrite_D=0.
- Write x7 with random data, pulse rst → RD2_D for rs2=7 reads 0 immediately and after deassert.

Source files
------------

// File: rtl/decode_stage.sv
// Decode stage of the RV64I+Zba pipeline: register file with write-to-read bypass, control decode, immediate generation.
// Zba encodings (SH1ADD/SH2ADD/SH3ADD, ADD.UW) are decoded only when the macro ZBA_EN is defined.
module decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Instr_D,
  input  logic [63:0] PC_D_in,
  input  logic        RegWrite_W,
  input  logic [4:0]  Rd_W,
  input  logic [63:0] Result_W,
  output logic [63:0] RD1_D,
  output logic [63:0] RD2_D,
  output logic [63:0] PC_D,
  output logic [63:0] ImmExt_D,
  output logic [4:0]  Rd_D,
  output logic [4:0]  Rs1_D,
  output logic [4:0]  Rs2_D,
  output logic [2:0]  Funct3_D,
  output logic        RegWrite_D,
  output logic        MemWrite_D,
  output logic        ALUSrc_D,
  output logic        Branch_D,
  output logic        Jump_D,
  output logic [1:0]  ResultSrc_D,
  output logic [3:0]  ALUControl_D,
  output logic        Illegal_D
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP32   = 7'b0111011;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b0001;
  localparam logic [3:0] ALU_AND    = 4'b0010;
  localparam logic [3:0] ALU_OR     = 4'b0011;
  localparam logic [3:0] ALU_XOR    = 4'b0100;
  localparam logic [3:0] ALU_SLL    = 4'b0101;
  localparam logic [3:0] ALU_SRL    = 4'b0110;
  localparam logic [3:0] ALU_SRA    = 4'b0111;
  localparam logic [3:0] ALU_SLT    = 4'b1000;
  localparam logic [3:0] ALU_SLTU   = 4'b1001;
`ifdef ZBA_EN
  localparam logic [3:0] ALU_SH1ADD = 4'b1010;
  localparam logic [3:0] ALU_SH2ADD = 4'b1011;
  localparam logic [3:0] ALU_SH3ADD = 4'b1100;
  localparam logic [3:0] ALU_ADDUW  = 4'b1101;
`endif

  localparam logic [1:0] RES_ALU   = 2'b00;
  localparam logic [1:0] RES_MEM   = 2'b01;
  localparam logic [1:0] RES_PC4   = 2'b10;
  localparam logic [1:0] RES_PCIMM = 2'b11;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [5:0]  w_funct6;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic        w_byp_en;
  logic [63:0] r_regs [0:31];

  assign w_opcode = Instr_D[6:0];
  assign w_funct3 = Instr_D[14:12];
  assign w_funct7 = Instr_D[31:25];
  assign w_funct6 = Instr_D[31:26];
  // LUI has no rs1; forcing 0 keeps the hazard unit from seeing a false dependency.
  assign w_rs1    = (w_opcode == OPC_LUI) ? 5'd0 : Instr_D[19:15];
  assign w_rs2    = Instr_D[24:20];

  assign Rs1_D    = w_rs1;
  assign Rs2_D    = w_rs2;
  assign Rd_D     = Instr_D[11:7];
  assign Funct3_D = w_funct3;
  assign PC_D     = PC_D_in;

  always_comb begin
    RegWrite_D   = 1'b0;
    MemWrite_D   = 1'b0;
    ALUSrc_D     = 1'b0;
    Branch_D     = 1'b0;
    Jump_D       = 1'b0;
    ResultSrc_D  = RES_ALU;
    ALUControl_D = ALU_ADD;
    Illegal_D    = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        RegWrite_D = 1'b1;
        case ({w_funct7, w_funct3})
          {7'b0000000, 3'b000}: ALUControl_D = ALU_ADD;
          {7'b0100000, 3'b000}: ALUControl_D = ALU_SUB;
          {7'b0000000, 3'b001}: ALUControl_D = ALU_SLL;
          {7'b0000000, 3'b010}: ALUControl_D = ALU_SLT;
          {7'b0000000, 3'b011}: ALUControl_D = ALU_SLTU;
          {7'b0000000, 3'b100}: ALUControl_D = ALU_XOR;
          {7'b0000000, 3'b101}: ALUControl_D = ALU_SRL;
          {7'b0100000, 3'b101}: ALUControl_D = ALU_SRA;
          {7'b0000000, 3'b110}: ALUControl_D = ALU_OR;
          {7'b0000000, 3'b111}: ALUControl_D = ALU_AND;
`ifdef ZBA_EN
          {7'b0010000, 3'b010}: ALUControl_D = ALU_SH1ADD;
          {7'b0010000, 3'b100}: ALUControl_D = ALU_SH2ADD;
          {7'b0010000, 3'b110}: ALUControl_D = ALU_SH3ADD;
`endif
          default:              Illegal_D    = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        RegWrite_D = 1'b1;
        ALUSrc_D   = 1'b1;
        case (w_funct3)
          3'b000: ALUControl_D = ALU_ADD;
          3'b010: ALUControl_D = ALU_SLT;
          3'b011: ALUControl_D = ALU_SLTU;
          3'b100: ALUControl_D = ALU_XOR;
          3'b110: ALUControl_D = ALU_OR;
          3'b111: ALUControl_D = ALU_AND;
          3'b001: begin
            if (w_funct6 == 6'b000000) ALUControl_D = ALU_SLL;
            else                       Illegal_D    = 1'b1;
          end
          3'b101: begin
            if (w_funct6 == 6'b000000)      ALUControl_D = ALU_SRL;
            else if (w_funct6 == 6'b010000) ALUControl_D = ALU_SRA;
            else                            Illegal_D    = 1'b1;
          end
        endcase
      end
      OPC_LOAD: begin
        RegWrite_D  = 1'b1;
        ALUSrc_D    = 1'b1;
        ResultSrc_D = RES_MEM;
        if (w_funct3 == 3'b111) Illegal_D = 1'b1;
      end
      OPC_STORE: begin
        MemWrite_D = 1'b1;
        ALUSrc_D   = 1'b1;
        if (w_funct3[2]) Illegal_D = 1'b1;
      end
      OPC_BRANCH: begin
        Branch_D = 1'b1;
        // Branch polarity (BEQ vs BNE etc.) is resolved downstream from Funct3_D.
        case (w_funct3)
          3'b000, 3'b001: ALUControl_D = ALU_SUB;
          3'b100, 3'b101: ALUControl_D = ALU_SLT;
          3'b110, 3'b111: ALUControl_D = ALU_SLTU;
          default:        Illegal_D    = 1'b1;
        endcase
      end
      OPC_JAL: begin
        Jump_D      = 1'b1;
        RegWrite_D  = 1'b1;
        ResultSrc_D = RES_PC4;
      end
      OPC_JALR: begin
        Jump_D      = 1'b1;
        RegWrite_D  = 1'b1;
        ResultSrc_D = RES_PC4;
        ALUSrc_D    = 1'b1;
        if (w_funct3 != 3'b000) Illegal_D = 1'b1;
      end
      OPC_LUI: begin
        RegWrite_D = 1'b1;
        ALUSrc_D   = 1'b1;
      end
      OPC_AUIPC: begin
        RegWrite_D  = 1'b1;
        ResultSrc_D = RES_PCIMM;
      end
      OPC_OP32: begin
`ifdef ZBA_EN
        if ({w_funct7, w_funct3} == {7'b0000100, 3'b000}) begin
          RegWrite_D   = 1'b1;
          ALUControl_D = ALU_ADDUW;
        end else begin
          Illegal_D = 1'b1;
        end
`else
        Illegal_D = 1'b1;
`endif
      end
      default: Illegal_D = 1'b1;
    endcase
    // An illegal instruction must behave as a bubble.
    if (Illegal_D) begin
      RegWrite_D   = 1'b0;
      MemWrite_D   = 1'b0;
      ALUSrc_D     = 1'b0;
      Branch_D     = 1'b0;
      Jump_D       = 1'b0;
      ResultSrc_D  = RES_ALU;
      ALUControl_D = ALU_ADD;
    end
  end

  always_comb begin
    ImmExt_D = 64'd0;
    case (w_opcode)
      OPC_OPIMM, OPC_LOAD, OPC_JALR:
        ImmExt_D = {{52{Instr_D[31]}}, Instr_D[31:20]};
      OPC_STORE:
        ImmExt_D = {{52{Instr_D[31]}}, Instr_D[31:25], Instr_D[11:7]};
      OPC_BRANCH:
        ImmExt_D = {{52{Instr_D[31]}}, Instr_D[7], Instr_D[30:25], Instr_D[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        ImmExt_D = {{32{Instr_D[31]}}, Instr_D[31:12], 12'd0};
      OPC_JAL:
        ImmExt_D = {{44{Instr_D[31]}}, Instr_D[19:12], Instr_D[20], Instr_D[30:21], 1'b0};
      default:
        ImmExt_D = 64'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= 64'd0;
    end else if (RegWrite_W && (Rd_W != 5'd0)) begin
      r_regs[Rd_W] <= Result_W;
    end
  end

  // Bypass is held off during reset so reads see the cleared file, not an in-flight write.
  assign w_byp_en = RegWrite_W && (Rd_W != 5'd0) && !rst;

  assign RD1_D = (w_rs1 == 5'd0)                  ? 64'd0    :
                 (w_byp_en && (Rd_W == w_rs1))    ? Result_W : r_regs[w_rs1];
  assign RD2_D = (w_rs2 == 5'd0)                  ? 64'd0    :
                 (w_byp_en && (Rd_W == w_rs2))    ? Result_W : r_regs[w_rs2];

endmodule
